mp_adder_sequencer: RTL

- Time-shares one external 16-bit carry-lookahead word adder between two requesters.
- Each request is a multi-precision add or subtract of 1 to 4 words (16 to 64 bits).
- The block sequences the request through the adder one 16-bit word per cycle, least-significant word first, chaining the carry through a register.
- It sits between requester logic and the shared adder, and drives every adder input.

---
 rtl/mp_adder_sequencer.sv | 108 ++++++++++
 1 files changed

// File: rtl/mp_adder_sequencer.sv
// mp_adder_sequencer: arbitrates two requesters onto one shared 16-bit adder and
// walks each 1..4 word add/subtract through it LSW first, chaining the carry.
module mp_adder_sequencer #(
    parameter int MAX_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic                     req0_sub,
    input  logic [1:0]               req0_len,
    input  logic [16*MAX_WORDS-1:0]  req0_a,
    input  logic [16*MAX_WORDS-1:0]  req0_b,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic                     req1_sub,
    input  logic [1:0]               req1_len,
    input  logic [16*MAX_WORDS-1:0]  req1_a,
    input  logic [16*MAX_WORDS-1:0]  req1_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_id,
    output logic [16*MAX_WORDS-1:0]  resp_sum,
    output logic                     resp_cout,
    output logic                     resp_ovf,
    output logic                     resp_zero,
    output logic [15:0]              add_a,
    output logic [15:0]              add_b,
    output logic                     add_cin,
    input  logic [15:0]              add_sum,
    input  logic                     add_cout,
    input  logic                     add_ovf,
    output logic                     busy
);
    localparam int W = 16 * MAX_WORDS;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t          r_state;
    logic            r_favor1, r_sub, r_id, r_carry, r_cout, r_ovf;
    logic [1:0]      r_len, r_k;
    logic [W-1:0]    r_a, r_b, r_sum;
    logic            w_idle, w_run, w_gnt0, w_gnt1;
    logic [5:0]      w_off;
    logic [15:0]     w_bw;
    // ready is gated by rst so no grant is visible while reset is asserted
    assign w_idle     = (r_state == IDLE) && !rst;
    assign w_run      = (r_state == RUN);
    assign w_gnt0     = w_idle && req0_valid && (!req1_valid || !r_favor1);
    assign w_gnt1     = w_idle && req1_valid && (!req0_valid || r_favor1);
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign w_off      = {r_k, 4'b0000};
    assign w_bw       = r_b[w_off +: 16];
    assign add_a      = w_run ? r_a[w_off +: 16] : 16'h0000;
    assign add_b      = w_run ? (r_sub ? ~w_bw : w_bw) : 16'h0000;
    assign add_cin    = w_run && ((r_k == 2'd0) ? r_sub : r_carry);
    assign resp_valid = (r_state == DONE);
    assign resp_id    = r_id;
    assign resp_sum   = r_sum;
    assign resp_cout  = r_cout;
    assign resp_ovf   = r_ovf;
    assign resp_zero  = resp_valid && (r_sum == '0);
    assign busy       = (r_state != IDLE);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_favor1 <= 1'b0;
            r_sub    <= 1'b0;
            r_id     <= 1'b0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_len    <= 2'd0;
            r_k      <= 2'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_gnt0 || w_gnt1) begin
                    r_id    <= w_gnt1;
                    r_sub   <= w_gnt1 ? req1_sub : req0_sub;
                    r_len   <= w_gnt1 ? req1_len : req0_len;
                    r_a     <= w_gnt1 ? req1_a : req0_a;
                    r_b     <= w_gnt1 ? req1_b : req0_b;
                    r_sum   <= '0;
                    r_k     <= 2'd0;
                    r_state <= RUN;
                end
                RUN: begin
                    r_sum[w_off +: 16] <= add_sum;
                    r_carry            <= add_cout;
                    if (r_k == r_len) begin
                        r_cout  <= add_cout;
                        r_ovf   <= add_ovf;
                        r_state <= DONE;
                    end else begin
                        r_k <= r_k + 2'd1;
                    end
                end
                DONE: if (resp_ready) begin
                    r_favor1 <= ~r_id;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
